// File: rtl/ps2_device_tx_if.sv
// Host-side bundle for the PS/2 device transmitter: byte push, status flags and the two line outputs.
// Define PS2_TX_ERR_INJECT_EN to add the err_inj parity-corruption input.
interface ps2_device_tx_if;
   logic [7:0] din;
   logic       din_valid;
   logic       full;
   logic       busy;
   logic       overflow;
   logic       ps2_clk;
   logic       ps2_data;
`ifdef PS2_TX_ERR_INJECT_EN
   logic       err_inj;

   modport master (
      output din, din_valid, err_inj,
      input  full, busy, overflow, ps2_clk, ps2_data
   );

   modport slave (
      input  din, din_valid, err_inj,
      output full, busy, overflow, ps2_clk, ps2_data
   );
`else
   modport master (
      output din, din_valid,
      input  full, busy, overflow, ps2_clk, ps2_data
   );

   modport slave (
      input  din, din_valid,
      output full, busy, overflow, ps2_clk, ps2_data
   );
`endif
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host serializer behind an 8-entry byte FIFO; start bit appears one cycle after a push into an idle block.
// Pushes into a full FIFO are dropped and latch overflow; macro PS2_TX_ERR_INJECT_EN adds err_inj to force even parity.
module ps2_device_tx #(
   parameter int CLK_DIV    = 16,
   parameter int GAP_CYCLES = 32
) (
   input  logic          clk,
   input  logic          rst,
   ps2_device_tx_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      GAP   = 2'd2
   } state_e;

   localparam logic [10:0] HALF     = 11'(CLK_DIV);
   localparam logic [10:0] BIT_LAST = 11'(2 * CLK_DIV - 1);
   localparam logic [10:0] GAP_LAST = 11'(GAP_CYCLES - 1);
   localparam logic [3:0]  IDX_STOP = 4'd10;

   logic [7:0]  mem_q [8];
   logic [2:0]  wr_ptr_q;
   logic [2:0]  rd_ptr_q;
   logic [3:0]  count_q;
   logic        overflow_q;

   state_e      state_q,    state_d;
   logic [10:0] frame_q,    frame_d;
   logic [3:0]  bit_idx_q,  bit_idx_d;
   logic [10:0] div_q,      div_d;
   logic        ps2_clk_q,  ps2_clk_d;
   logic        ps2_data_q, ps2_data_d;

   logic        full;
   logic        push;
   logic        pop;
   logic [7:0]  head;
   logic        parity;

   assign full = (count_q == 4'd8);
   assign push = bus.din_valid & ~full;
   assign head = mem_q[rd_ptr_q];

`ifdef PS2_TX_ERR_INJECT_EN
   assign parity = ~(^head) ^ bus.err_inj;
`else
   assign parity = ~(^head);
`endif

   // Storage needs no reset: only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= 3'd0;
         rd_ptr_q   <= 3'd0;
         count_q    <= 4'd0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 3'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 3'd1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 4'd1;
            2'b01:   count_q <= count_q - 4'd1;
            default: count_q <= count_q;
         endcase
         if (bus.din_valid && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         frame_q    <= 11'h7FF;
         bit_idx_q  <= 4'd0;
         div_q      <= 11'd0;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_idx_q  <= bit_idx_d;
         div_q      <= div_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
      end
   end

   // Line levels are computed for the state being entered so they leave the flops already aligned with it.
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      bit_idx_d  = bit_idx_q;
      div_d      = div_q;
      ps2_clk_d  = 1'b1;
      ps2_data_d = 1'b1;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q != 4'd0) begin
               pop        = 1'b1;
               frame_d    = {1'b1, parity, head, 1'b0};
               bit_idx_d  = 4'd0;
               div_d      = 11'd0;
               state_d    = FRAME;
               ps2_data_d = 1'b0;
            end
         end

         FRAME: begin
            if (div_q == BIT_LAST) begin
               div_d = 11'd0;
               if (bit_idx_q == IDX_STOP) begin
                  state_d = GAP;
               end else begin
                  bit_idx_d  = bit_idx_q + 4'd1;
                  ps2_data_d = frame_q[bit_idx_d];
               end
            end else begin
               div_d      = div_q + 11'd1;
               ps2_clk_d  = (div_d < HALF);
               ps2_data_d = frame_q[bit_idx_q];
            end
         end

         GAP: begin
            if (div_q == GAP_LAST) begin
               div_d   = 11'd0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 11'd1;
            end
         end

         default: begin
            state_d = IDLE;
            div_d   = 11'd0;
         end
      endcase
   end

   assign bus.full     = full;
   assign bus.busy     = (state_q != IDLE);
   assign bus.overflow = overflow_q;
   assign bus.ps2_clk  = ps2_clk_q;
   assign bus.ps2_data = ps2_data_q;

endmodule
